// File: rtl/capture_arbiter.sv
// Round-robin arbiter/sequencer sharing one capture register between N_REQ requesters.
// Each transaction: arbitrate, hold D for SETUP_CYC cycles, capture, then respond.
module capture_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned SETUP_CYC = 1
) (
  input  logic                     CP,
  input  logic                     CDN,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DW-1:0]      req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DW-1:0]            rsp_data,
  output logic [$clog2(N_REQ)-1:0] rsp_id
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {StIdle, StSetup, StCapt, StResp} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [IW-1:0]   id_q, id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   cap_q, cap_d;
  logic [DW-1:0]   d_mux;
  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   scan_idx;

  // First set request scanning upward from ptr with wrap-around.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      scan_idx = IW'((32'(ptr_q) + off) % N_REQ);
      if (!win_valid && req[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // D input of the shared capture register follows the selected requester.
  assign d_mux = req_data[32'(sel_q) * DW +: DW];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          sel_d   = win_idx;
          cnt_d   = CW'(SETUP_CYC - 1);
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (!req[sel_q]) begin
          state_d = StIdle;
        end else if (cnt_q == '0) begin
          state_d = StCapt;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      StCapt: begin
        cap_d   = d_mux;
        id_d    = sel_q;
        ptr_d   = (sel_q == IW'(N_REQ - 1)) ? '0 : sel_q + IW'(1);
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CP or negedge CDN) begin
    if (!CDN) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    gnt = '0;
    if (state_q == StCapt) begin
      gnt[sel_q] = 1'b1;
    end
  end

  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = cap_q;
  assign rsp_id    = id_q;

endmodule
